// File: rtl/maxpool1d_if.sv
// Handshake and flat data bus between a conv1d producer and the maxpool1d stage.
// MAXPOOL1D_ARGMAX_EN adds the idx_out argmax bus.
interface maxpool1d_if #(
  parameter int unsigned IN_LEN = 780,
  parameter int unsigned CH     = 4,
  parameter int unsigned POOL   = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned BITS   = 31
);
  localparam int unsigned OUT_LEN = (IN_LEN - POOL) / STRIDE + 1;

  logic                           start;
  logic [IN_LEN*CH-1:0][BITS:0]   data_in;
  logic [OUT_LEN*CH-1:0][BITS:0]  data_out;
  logic                           busy;
  logic                           done;
`ifdef MAXPOOL1D_ARGMAX_EN
  logic [OUT_LEN*CH-1:0][7:0]     idx_out;

  modport master (output start, data_in, input data_out, busy, done, idx_out);
  modport slave  (input start, data_in, output data_out, busy, done, idx_out);
`else
  modport master (output start, data_in, input data_out, busy, done);
  modport slave  (input start, data_in, output data_out, busy, done);
`endif
endinterface

// File: rtl/maxpool1d.sv
// Sequential 1D signed max-pooling over all channels in parallel, fed by conv1d.
// MAXPOOL1D_ARGMAX_EN adds per-output in-window argmax (idx_out).
module maxpool1d #(
  parameter int unsigned IN_LEN = 780,
  parameter int unsigned CH     = 4,
  parameter int unsigned POOL   = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned BITS   = 31
) (
  input logic       clk,
  input logic       rstn,
  maxpool1d_if.slave bus
);
  localparam int unsigned OUT_LEN = (IN_LEN - POOL) / STRIDE + 1;
  localparam int unsigned TW      = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned PW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, STORE} state_t;

  state_t                         r_state, w_state_nxt;
  logic [PW-1:0]                  r_pos, w_pos_nxt;
  logic [TW-1:0]                  r_tap, w_tap_nxt;
  logic                           r_done, w_done_nxt;
  logic                           w_scan, w_store;
  int unsigned                    w_off;
  logic [CH-1:0][BITS:0]          w_x;
  logic [CH-1:0][BITS:0]          r_max;
  logic [OUT_LEN*CH-1:0][BITS:0]  r_data_out;
`ifdef MAXPOOL1D_ARGMAX_EN
  logic [CH-1:0][7:0]             r_idx;
  logic [OUT_LEN*CH-1:0][7:0]     r_idx_out;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_tap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_tap   <= w_tap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_tap_nxt   = r_tap;
    w_done_nxt  = 1'b0;
    w_scan      = 1'b0;
    w_store     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_pos_nxt   = '0;
          w_tap_nxt   = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_scan = 1'b1;
        if (r_tap == TW'(POOL - 1)) begin
          w_tap_nxt   = '0;
          w_state_nxt = STORE;
        end else begin
          w_tap_nxt = r_tap + TW'(1);
        end
      end
      STORE: begin
        w_store = 1'b1;
        if (r_pos == PW'(OUT_LEN - 1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_pos_nxt   = r_pos + PW'(1);
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // pos and tap are always in range, so the tap address never leaves the channel's slice
  always_comb begin
    w_x   = '0;
    w_off = 32'(r_pos) * STRIDE + 32'(r_tap);
    for (int unsigned c = 0; c < CH; c++) begin
      w_x[c] = bus.data_in[c*IN_LEN + w_off];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_max      <= '0;
      r_data_out <= '0;
`ifdef MAXPOOL1D_ARGMAX_EN
      r_idx      <= '0;
      r_idx_out  <= '0;
`endif
    end else begin
      for (int unsigned c = 0; c < CH; c++) begin
        // strict '>' keeps the earliest element on ties
        if (w_scan && ((r_tap == '0) || ($signed(w_x[c]) > $signed(r_max[c])))) begin
          r_max[c] <= w_x[c];
`ifdef MAXPOOL1D_ARGMAX_EN
          r_idx[c] <= 8'(r_tap);
`endif
        end
        if (w_store) begin
          r_data_out[c*OUT_LEN + 32'(r_pos)] <= r_max[c];
`ifdef MAXPOOL1D_ARGMAX_EN
          r_idx_out[c*OUT_LEN + 32'(r_pos)] <= r_idx[c];
`endif
        end
      end
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
`ifdef MAXPOOL1D_ARGMAX_EN
  assign bus.idx_out  = r_idx_out;
`endif

endmodule

// File: tb/tb_maxpool1d.sv
// Directed self-checking bench for maxpool1d: default 780x4 instance plus a small
// overlapping-window instance (11x2, POOL=3, STRIDE=2).
module tb_maxpool1d;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  maxpool1d_if #(.IN_LEN(780), .CH(4), .POOL(2), .STRIDE(2), .BITS(31)) a_if ();
  maxpool1d_if #(.IN_LEN(11),  .CH(2), .POOL(3), .STRIDE(2), .BITS(31)) b_if ();

  maxpool1d #(.IN_LEN(780), .CH(4), .POOL(2), .STRIDE(2), .BITS(31)) u_a (
    .clk(clk), .rstn(rstn), .bus(a_if));
  maxpool1d #(.IN_LEN(11),  .CH(2), .POOL(3), .STRIDE(2), .BITS(31)) u_b (
    .clk(clk), .rstn(rstn), .bus(b_if));

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_a  [1560];
  logic [7:0]  exp_ai [1560];
  logic [31:0] bx     [22];
  logic [31:0] exp_b  [10];
  logic [7:0]  exp_bi [10];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // data_in[i] = (i+ofs)<<16; window p of channel c holds elements c*780+2p, +1
  task automatic load_ramp(input int ofs);
    for (int i = 0; i < 3120; i++) a_if.data_in[i] = 32'((i + ofs) << 16);
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 390; p++) begin
        exp_a[c*390+p]  = 32'((c*780 + 2*p + 1 + ofs) << 16);
        exp_ai[c*390+p] = 8'd1;
      end
  endtask

  function automatic int bad_a();
    int n = 0;
    for (int k = 0; k < 1560; k++) begin
      if (a_if.data_out[k] !== exp_a[k]) n++;
`ifdef MAXPOOL1D_ARGMAX_EN
      if (a_if.idx_out[k] !== exp_ai[k]) n++;
`endif
    end
    return n;
  endfunction

  function automatic int nonzero_a();
    int n = 0;
    for (int k = 0; k < 1560; k++) begin
      if (a_if.data_out[k] !== 32'h0) n++;
`ifdef MAXPOOL1D_ARGMAX_EN
      if (a_if.idx_out[k] !== 8'h0) n++;
`endif
    end
    return n;
  endfunction

  // Pulse start, then watch 1400 edges; optionally hold start high mid-pass.
  task automatic run_a(input int hold_at, output int first_done, output int ndone);
    @(negedge clk);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    check("busy_after_start", a_if.busy, 1);
    first_done = -1;
    ndone = 0;
    for (int cyc = 1; cyc <= 1400; cyc++) begin
      a_if.start = (cyc > hold_at) && (cyc <= hold_at + 10);
      @(posedge clk);
      #1;
      if (a_if.done) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end
    end
    a_if.start = 1'b0;
  endtask

  task automatic run_b(input string tag);
    int cyc;
    for (int i = 0; i < 22; i++) begin
      bx[i] = $urandom;
      b_if.data_in[i] = bx[i];
    end
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 5; p++) begin
        logic [31:0] m;
        logic [7:0]  mi;
        m  = bx[c*11 + p*2];
        mi = 8'd0;
        for (int t = 1; t < 3; t++)
          if ($signed(bx[c*11 + p*2 + t]) > $signed(m)) begin
            m  = bx[c*11 + p*2 + t];
            mi = 8'(t);
          end
        exp_b[c*5+p]  = m;
        exp_bi[c*5+p] = mi;
      end
    @(negedge clk);
    b_if.start = 1'b1;
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    cyc = 0;
    while (!b_if.done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_done_cyc"}, 64'(cyc), 20);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_out%0d", tag, k), b_if.data_out[k], exp_b[k]);
`ifdef MAXPOOL1D_ARGMAX_EN
      check($sformatf("%s_idx%0d", tag, k), b_if.idx_out[k], exp_bi[k]);
`endif
    end
  endtask

  initial begin
    int fd, nd;
    rstn = 1'b0;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.data_in = '0;
    b_if.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_out_zero", 64'(nonzero_a()), 0);
    check("rst_b_busy", b_if.busy, 0);
    rstn = 1'b1;

    // plain ramp pass
    load_ramp(0);
    run_a(100000, fd, nd);
    check("p1_done_cyc", 64'(fd), 1170);
    check("p1_done_cnt", 64'(nd), 1);
    check("p1_out0", a_if.data_out[0], 32'h0001_0000);
    check("p1_out390", a_if.data_out[390], 32'h030D_0000);
    check("p1_out1559", a_if.data_out[1559], 32'h0C2F_0000);
    check("p1_all", 64'(bad_a()), 0);

    // start held high for 10 cycles mid-pass must be ignored
    load_ramp(1);
    run_a(200, fd, nd);
    check("p2_done_cyc", 64'(fd), 1170);
    check("p2_done_cnt", 64'(nd), 1);
    check("p2_out0", a_if.data_out[0], 32'h0002_0000);
    check("p2_all", 64'(bad_a()), 0);

    // reset at cycle 500 of a pass
    load_ramp(0);
    @(negedge clk);
    a_if.start = 1'b1;
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    for (int k = 1; k < 500; k++) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", a_if.busy, 0);
    check("mid_rst_done", a_if.done, 0);
    check("mid_rst_zero", 64'(nonzero_a()), 0);
    rstn = 1'b1;
    run_a(100000, fd, nd);
    check("p4_done_cyc", 64'(fd), 1170);
    check("p4_done_cnt", 64'(nd), 1);
    check("p4_all", 64'(bad_a()), 0);

    // negative values, zero crossing, tie, later max in ch0 windows 0..3
    a_if.data_in[0] = 32'hFFFD_0000;
    a_if.data_in[1] = 32'hFFFB_0000;
    a_if.data_in[2] = 32'hFFFF_0000;
    a_if.data_in[3] = 32'h0000_0000;
    a_if.data_in[4] = 32'h0002_0000;
    a_if.data_in[5] = 32'h0002_0000;
    a_if.data_in[6] = 32'h0001_0000;
    a_if.data_in[7] = 32'h0004_0000;
    exp_a[0] = 32'hFFFD_0000; exp_ai[0] = 8'd0;
    exp_a[1] = 32'h0000_0000; exp_ai[1] = 8'd1;
    exp_a[2] = 32'h0002_0000; exp_ai[2] = 8'd0;
    exp_a[3] = 32'h0004_0000; exp_ai[3] = 8'd1;
    run_a(100000, fd, nd);
    check("p5_done_cyc", 64'(fd), 1170);
    check("neg_max", a_if.data_out[0], 32'hFFFD_0000);
    check("neg_zero", a_if.data_out[1], 32'h0000_0000);
    check("tie_val", a_if.data_out[2], 32'h0002_0000);
    check("late_max", a_if.data_out[3], 32'h0004_0000);
`ifdef MAXPOOL1D_ARGMAX_EN
    check("idx_neg", a_if.idx_out[0], 0);
    check("idx_zero", a_if.idx_out[1], 1);
    check("idx_tie", a_if.idx_out[2], 0);
    check("idx_late", a_if.idx_out[3], 1);
`endif
    check("p5_all", 64'(bad_a()), 0);

    // small overlapping-window instance, random signed data
    run_b("b1");
    run_b("b2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
